// File: rtl/m_key_cond.sv
// m_key_cond: two independent debounce + press/long/short classifiers for the
// active-low front-panel buttons feeding the watch core.

module m_key_cond_chan #(
  parameter int DEB_CYC  = 4,
  parameter int LONG_CYC = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_first,
  output logic key_long,
  output logic key_short
);

  localparam int DW = (DEB_CYC  > 1) ? $clog2(DEB_CYC + 1)  : 1;
  localparam int HW = (LONG_CYC > 1) ? $clog2(LONG_CYC + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  state_t          state_r;
  logic            sync1_r;
  logic            sync2_r;
  logic            pressed_s;
  logic            db_r;
  logic            db_d_r;
  logic [DW-1:0]   deb_cnt_r;
  logic [HW-1:0]   hold_cnt_r;

  assign pressed_s = ~sync2_r;

  // Two-flop synchronizer; both stages rest at 1 so reset reads as "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: db follows pressed_s only after DEB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r      <= 1'b0;
      deb_cnt_r <= {DW{1'b0}};
    end else if (pressed_s == db_r) begin
      deb_cnt_r <= {DW{1'b0}};
    end else if (deb_cnt_r == DEB_LAST) begin
      db_r      <= pressed_s;
      deb_cnt_r <= {DW{1'b0}};
    end else begin
      deb_cnt_r <= deb_cnt_r + DW'(1);
    end
  end

  // Delayed copy of db; the FSM acts on this so press/release latency is DEB_CYC+3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_d_r <= 1'b0;
    end else begin
      db_d_r <= db_r;
    end
  end

  // Press classifier; a release seen on the same cycle the hold completes counts as short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= {HW{1'b0}};
      key_first  <= 1'b0;
      key_long   <= 1'b0;
      key_short  <= 1'b0;
    end else begin
      key_first <= 1'b0;
      key_short <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (db_d_r) begin
            key_first  <= 1'b1;
            hold_cnt_r <= {HW{1'b0}};
            state_r    <= ST_PRESS;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_PRESS: begin
          if (!db_d_r) begin
            key_short <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (hold_cnt_r == LONG_LAST) begin
            key_long  <= 1'b1;
            state_r   <= ST_LONG;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        ST_LONG: begin
          if (!db_d_r) begin
            key_long <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            key_long <= 1'b1;
          end
        end
        default: begin
          key_long <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

module m_key_cond #(
  parameter int IN_CLK_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_1,
  input  logic key_n_2,
  output logic key_first_1,
  output logic key_first_2,
  output logic key_long_1,
  output logic key_long_2,
  output logic key_short_1,
  output logic key_short_2
);

  localparam int CYC_MS   = IN_CLK_HZ / 1000;
  localparam int DEB_CYC  = CYC_MS * DEBOUNCE_MS;
  localparam int LONG_CYC = CYC_MS * LONG_MS;

  generate
    if (!((LONG_MS > DEBOUNCE_MS) && (DEBOUNCE_MS >= 1))) begin : g_bad_cfg
      $error("m_key_cond: need LONG_MS > DEBOUNCE_MS and DEBOUNCE_MS >= 1");
    end
  endgenerate

  m_key_cond_chan #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC)) u_chan_1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n_1),
    .key_first (key_first_1),
    .key_long  (key_long_1),
    .key_short (key_short_1)
  );

  m_key_cond_chan #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC)) u_chan_2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n_2),
    .key_first (key_first_2),
    .key_long  (key_long_2),
    .key_short (key_short_2)
  );

endmodule

// File: tb/tb_m_key_cond.sv
// tb_m_key_cond: directed + random stimulus, reference model feeds a queue of
// expected outputs that a negedge monitor pops and compares.

module tb_m_key_cond;

  localparam int IN_CLK_HZ   = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int LONG_MS     = 20;
  localparam int DEB_CYC     = 4;
  localparam int LONG_CYC    = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n_1 = 1'b1;
  logic key_n_2 = 1'b1;
  logic key_first_1, key_first_2, key_long_1, key_long_2, key_short_1, key_short_2;

  m_key_cond #(.IN_CLK_HZ(IN_CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n_1     (key_n_1),
    .key_n_2     (key_n_2),
    .key_first_1 (key_first_1),
    .key_first_2 (key_first_2),
    .key_long_1  (key_long_1),
    .key_long_2  (key_long_2),
    .key_short_1 (key_short_1),
    .key_short_2 (key_short_2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic f1; logic l1; logic s1;
    logic f2; logic l2; logic s2;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n = 0;

  // reference model state: raw sample delay, debounce window, debounced history
  bit raw_h [2][2];
  bit win   [2][DEB_CYC];
  bit dbh   [2][3];
  bit db    [2];
  int age   [2];

  // event log gathered by the monitor for directed timing checks
  int   first_cnt[2], short_cnt[2], rise_cnt[2];
  int   last_first[2], last_short[2], last_rise[2], last_fall[2];
  logic prev_long[2];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      raw_h[k][0] = 1'b1; raw_h[k][1] = 1'b1;
      for (int i = 0; i < DEB_CYC; i++) win[k][i] = 1'b0;
      for (int i = 0; i < 3; i++) dbh[k][i] = 1'b0;
      db[k]  = 1'b0;
      age[k] = LONG_CYC + 1;
    end
  endtask

  task automatic model_step(input int k, input bit raw, output logic f, output logic l, output logic s);
    bit pressed, all_diff, cur, prev;
    pressed = !raw_h[k][0];
    raw_h[k][0] = raw_h[k][1];
    raw_h[k][1] = raw;
    for (int i = 0; i < DEB_CYC - 1; i++) win[k][i] = win[k][i+1];
    win[k][DEB_CYC-1] = pressed;
    all_diff = 1'b1;
    for (int i = 0; i < DEB_CYC; i++) if (win[k][i] == db[k]) all_diff = 1'b0;
    if (all_diff) db[k] = !db[k];
    prev = dbh[k][0];
    cur  = dbh[k][1];
    dbh[k][0] = dbh[k][1];
    dbh[k][1] = dbh[k][2];
    dbh[k][2] = db[k];
    if (cur && !prev) begin
      f = 1'b1;
      age[k] = 0;
    end else begin
      f = 1'b0;
      if (age[k] <= LONG_CYC) age[k]++;
    end
    l = cur && !f && (age[k] >= LONG_CYC);
    s = !cur && prev && (age[k] <= LONG_CYC);
  endtask

  // model: one expected vector per rising edge
  initial begin
    exp_t e;
    model_reset();
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        model_reset();
        e = '0;
      end else begin
        model_step(0, key_n_1, e.f1, e.l1, e.s1);
        model_step(1, key_n_2, e.f2, e.l2, e.s2);
      end
      exp_q.push_back(e);
    end
  end

  // monitor: compare on the falling edge and log events
  initial begin
    exp_t e;
    logic fo[2], lo[2], so[2];
    for (int k = 0; k < 2; k++) begin
      first_cnt[k] = 0; short_cnt[k] = 0; rise_cnt[k] = 0;
      last_first[k] = -1; last_short[k] = -1; last_rise[k] = -1; last_fall[k] = -1;
      prev_long[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("key_first_1", key_first_1, e.f1);
        check("key_long_1",  key_long_1,  e.l1);
        check("key_short_1", key_short_1, e.s1);
        check("key_first_2", key_first_2, e.f2);
        check("key_long_2",  key_long_2,  e.l2);
        check("key_short_2", key_short_2, e.s2);
      end
      fo[0] = key_first_1; lo[0] = key_long_1; so[0] = key_short_1;
      fo[1] = key_first_2; lo[1] = key_long_2; so[1] = key_short_2;
      for (int k = 0; k < 2; k++) begin
        if (fo[k]) begin first_cnt[k]++; last_first[k] = edge_n; end
        if (so[k]) begin short_cnt[k]++; last_short[k] = edge_n; end
        if (lo[k] && !prev_long[k]) begin rise_cnt[k]++; last_rise[k] = edge_n; end
        if (!lo[k] && prev_long[k]) last_fall[k] = edge_n;
        prev_long[k] = lo[k];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int c0, r0, f0, s0, l0;
    int run_left[2];
    logic lvl[2];

    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // clean short press on key 1
    key_n_1 = 1'b0; c0 = edge_n + 1; f0 = first_cnt[0]; s0 = short_cnt[0]; l0 = rise_cnt[0];
    cyc(10);
    key_n_1 = 1'b1; r0 = edge_n + 1;
    cyc(15);
    check("t1_first_edge", last_first[0], c0 + 7);
    check("t1_first_count", first_cnt[0] - f0, 1);
    check("t1_short_edge", last_short[0], r0 + 7);
    check("t1_short_count", short_cnt[0] - s0, 1);
    check("t1_no_long", rise_cnt[0] - l0, 0);

    // bouncing contact, then steady press
    f0 = first_cnt[0];
    for (int i = 0; i < 5; i++) begin
      key_n_1 = 1'b0; cyc(2);
      key_n_1 = 1'b1; cyc(2);
    end
    cyc(10);
    check("t2_bounce_silent", first_cnt[0] - f0, 0);
    key_n_1 = 1'b0;
    cyc(15);
    check("t2_single_first", first_cnt[0] - f0, 1);
    key_n_1 = 1'b1;
    cyc(15);

    // long hold on key 2
    key_n_2 = 1'b0; c0 = edge_n + 1; s0 = short_cnt[1];
    cyc(40);
    key_n_2 = 1'b1; r0 = edge_n + 1;
    cyc(15);
    check("t3_first_edge", last_first[1], c0 + 7);
    check("t3_long_rise", last_rise[1], c0 + 27);
    check("t3_long_fall", last_fall[1], r0 + 7);
    check("t3_no_short", short_cnt[1] - s0, 0);

    // both keys together, key 2 held on to long
    key_n_1 = 1'b0; key_n_2 = 1'b0; c0 = edge_n + 1; l0 = rise_cnt[0];
    cyc(12);
    key_n_1 = 1'b1;
    cyc(18);
    key_n_2 = 1'b1;
    cyc(15);
    check("t4_first_1", last_first[0], c0 + 7);
    check("t4_first_2", last_first[1], c0 + 7);
    check("t4_long_2", last_rise[1], c0 + 27);
    check("t4_no_long_1", rise_cnt[0] - l0, 0);

    // reset during a long hold on key 1
    key_n_1 = 1'b0;
    cyc(30);
    check("t5_long_before_rst", key_long_1, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_long_drop", key_long_1, 0);
    cyc(2);
    rst_n = 1'b1; c0 = edge_n + 1;
    cyc(12);
    check("t5_first_after_rst", last_first[0], c0 + 7);
    key_n_1 = 1'b1;
    cyc(20);

    // glitch below and at the debounce threshold on key 2
    f0 = first_cnt[1];
    key_n_2 = 1'b0; cyc(3);
    key_n_2 = 1'b1; cyc(15);
    check("t6_glitch3_silent", first_cnt[1] - f0, 0);
    key_n_2 = 1'b0; c0 = edge_n + 1; cyc(4);
    key_n_2 = 1'b1; cyc(15);
    check("t6_glitch4_first", first_cnt[1] - f0, 1);
    check("t6_glitch4_edge", last_first[1], c0 + 7);

    // random bouncing presses of varied length with rare resets
    lvl[0] = 1'b1; lvl[1] = 1'b1; run_left[0] = 0; run_left[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (run_left[k] == 0) begin
          lvl[k] = ~lvl[k];
          run_left[k] = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 6))
                                                    : int'($urandom_range(5, 40));
        end
        run_left[k]--;
      end
      key_n_1 = lvl[0];
      key_n_2 = lvl[1];
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    key_n_1 = 1'b1; key_n_2 = 1'b1; rst_n = 1'b1;
    cyc(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
